// File: rtl/stream_demux16_pkg.sv
// rtl/stream_demux16_pkg.sv - shared constants and FSM encoding for stream_demux16
package stream_demux16_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int CNT_W      = 16;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOCK0 = 2'd1;
    localparam logic [1:0] ST_LOCK1 = 2'd2;

endpackage

// File: rtl/stream_demux16_if.sv
// rtl/stream_demux16_if.sv - valid/ready word stream with last flag
interface stream_demux16_if
    import stream_demux16_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic [DATA_W-1:0] data;
    logic              last;
    logic              valid;
    logic              ready;

    modport master (output data, output last, output valid, input ready);
    modport slave  (input data, input last, input valid, output ready);
endinterface

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - small synchronous FIFO with head-of-queue output
module stream_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    // A full FIFO refuses a push even if a pop happens in the same cycle.
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rd_ptr];

    // Storage, pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/stream_demux16.sv
// rtl/stream_demux16.sv - packet-granular 1:2 stream demux with per-output FIFOs and counters
module stream_demux16
    import stream_demux16_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    stream_demux16_if.slave   s_in,
    input  logic              in_sel,
    stream_demux16_if.master  m_out0,
    stream_demux16_if.master  m_out1,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);
    state_t          r_state;
    logic            r_rdy_en;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    logic            w_route;
    logic            w_accept;
    logic            w_full0;
    logic            w_full1;
    logic            w_empty0;
    logic            w_empty1;
    logic            w_pop0;
    logic            w_pop1;
    logic [DATA_W:0] w_head0;
    logic [DATA_W:0] w_head1;

    // Route follows in_sel only between packets; inside a packet it is pinned by the state.
    assign w_route  = (r_state == ST_IDLE) ? in_sel : (r_state == ST_LOCK1);
    assign s_in.ready = r_rdy_en & ~(w_route ? w_full1 : w_full0);
    assign w_accept = s_in.valid & s_in.ready;
    assign w_pop0   = ~w_empty0 & m_out0.ready;
    assign w_pop1   = ~w_empty1 & m_out1.ready;

    stream_fifo #(.W(DATA_W + 1), .DEPTH(DEPTH)) u_fifo0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_accept & ~w_route),
        .i_data  ({s_in.last, s_in.data}),
        .i_pop   (w_pop0),
        .o_data  (w_head0),
        .o_full  (w_full0),
        .o_empty (w_empty0)
    );

    stream_fifo #(.W(DATA_W + 1), .DEPTH(DEPTH)) u_fifo1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_accept & w_route),
        .i_data  ({s_in.last, s_in.data}),
        .i_pop   (w_pop1),
        .o_data  (w_head1),
        .o_full  (w_full1),
        .o_empty (w_empty1)
    );

    assign m_out0.data  = w_head0[DATA_W-1:0];
    assign m_out0.last  = w_head0[DATA_W];
    assign m_out0.valid = ~w_empty0;
    assign m_out1.data  = w_head1[DATA_W-1:0];
    assign m_out1.last  = w_head1[DATA_W];
    assign m_out1.valid = ~w_empty1;
    assign cnt0 = r_cnt0;
    assign cnt1 = r_cnt1;

    // Input is held off for one cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rdy_en <= 1'b0;
        else        r_rdy_en <= 1'b1;
    end

    // Packet lock: first non-last word locks the route, the last word returns to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else if (w_accept) begin
            if (r_state == ST_IDLE) begin
                if (!s_in.last) r_state <= in_sel ? ST_LOCK1 : ST_LOCK0;
            end else if (s_in.last) begin
                r_state <= ST_IDLE;
            end
        end
    end

    // Delivered-word counters, wrapping at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_pop0) r_cnt0 <= r_cnt0 + CNT_W'(1);
            if (w_pop1) r_cnt1 <= r_cnt1 + CNT_W'(1);
        end
    end
endmodule

// File: doc/stream_demux16.md
# stream_demux16

Routes a 16-bit valid/ready word stream to one of two output streams. It is the split counterpart of the 16-bit 2:1 select mux in the datapath, for fan-out from one producer, such as a sensor or neuron-update stream, to two consumers. Routing is chosen per packet, not per word: the select is sampled on the first word and held until the word flagged last. Each output has its own small FIFO so a stalled consumer only blocks traffic routed to it, plus a delivered-word counter.

## Interface
- DATA_W, 16: word width.
- DEPTH, 2: per-output FIFO depth; power of two, ≥2.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_data  in  DATA_W  input word.
- in_sel  in  1  destination (0 → out0, 1 → out1); sampled only on the first word of a packet.
- in_last  in  1  marks the final word of a packet.
- in_valid  in  1  input word present.
- in_ready  out  1  block accepts the input word this cycle.
- out0_data / out1_data  out  DATA_W  head word of each FIFO.
- out0_last / out1_last  out  1  last flag carried with the head word.
- out0_valid / out1_valid  out  1  FIFO non-empty.
- out0_ready / out1_ready  in  1  consumer accepts the head word.
- cnt0 / cnt1  out  16  words delivered on each output; wraps.

## Operation
- Accept: in_valid & in_ready. Pop on output x: outx_valid & outx_ready.
- FSM states:
  - IDLE: route = in_sel (combinational).
    - Accepted word with in_last=0 → LOCK0 or LOCK1, per in_sel.
    - Accepted word with in_last=1 (single-word packet) → stay IDLE.
  - LOCK0 / LOCK1: route fixed at 0 / 1; in_sel ignored.
    - Accepted word with in_last=1 → IDLE.
- in_ready = rdy_en & !full[route].
  - rdy_en is a register cleared by reset and set on the first clk edge after rst_n rises.
  - in_ready never depends on outx_ready, so there is no combinational ready path from output to input.
  - in_ready depends combinationally on in_sel only in IDLE.
- Push: an accepted word, with its last flag, goes to the FIFO selected by route. The other FIFO is untouched.
- FIFO x:
  - Push and pop in the same cycle are allowed whenever not full.
  - When full, in_ready is low for that route even if a pop occurs that cycle.
  - Head data and last are stable while outx_valid=1 and outx_ready=0.
- Counters: cntx increments by 1 on each pop of output x; 16'hFFFF wraps to 0.
- A stall on one output never blocks a packet routed to the other output once the FSM is in IDLE or in the other LOCK state.

## Timing
- Reset (rst_n low, asynchronous):
  - FSM → IDLE; both FIFOs emptied.
  - in_ready=0, out0_valid=out1_valid=0, cnt0=cnt1=0.
  - out*_data and out*_last = 0.
- Reset mid-packet discards the partial packet. The first word after reset is treated as a packet start.
- Latency: a word accepted at edge N is visible on outx_valid/data after edge N, i.e. one cycle.
- Throughput: one word per cycle sustained per route while the consumer holds outx_ready=1, with DEPTH≥2.
- in_valid may be high while in_ready is low. Data must be held until accepted, per the standard valid/ready rule.

## Structure
- Shared package stream_demux16_pkg:
  - state enum {IDLE, LOCK0, LOCK1};
  - DATA_W default;
  - counter width 16.
- Sub-module stream_fifo (DATA_W+1 bits wide, DEPTH entries, push/pop/full/empty), instantiated twice.
- Top level holds the FSM, route mux, rdy_en and the counters.

## Test plan
- Reset release, 1-word packet: in_sel=1, in_last=1, data 16'hA5A5.
  - in_ready low in the first cycle after release.
  - Word appears on out1 one cycle after acceptance; out0_valid stays 0; after the pop, cnt1=1.
- Locked packet: 4 words 0x0001..0x0004, in_sel=0 on the first word, in_sel toggling afterwards, last on word 4.
  - All four words on out0 in order; out0_last only on 0x0004; FSM back to IDLE.
- Backpressure with DEPTH=2: out0_ready=0 and 3 words offered to out0.
  - Two words accepted, then in_ready=0.
  - Raising out0_ready resumes flow with no loss or duplication.
- Independence: out0 stalled and full; a packet with in_sel=1 is offered in IDLE.
  - It is accepted and delivered on out1 at 1 word/cycle.
- Counter wrap: preload by streaming 65536 words to out1 with out1_ready=1.
  - cnt1 returns to 0; cnt0 unchanged.
- Mid-packet reset: rst_n asserted after 2 of 5 words.
  - Outputs invalid and counters 0 immediately.
  - The next word, with in_sel=1, routes to out1 as a new packet.
